// File: rtl/wb_ctrl_pkg.sv
// wb_ctrl_pkg: shared widths, default queue depth and queue entry type for the writeback controller
package wb_ctrl_pkg;
  localparam int REG_NUM_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH_DEF = 4;
  typedef logic [REG_NUM_W-1:0] reg_num_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef struct packed {
    logic valid;
    reg_num_t num;
    data_t data;
  } wb_entry_t;
endpackage

// File: rtl/wb_ctrl_fifo.sv
// wb_fifo: in-order mem-side writeback queue with squash-by-register and per-entry pending match
module wb_fifo
  import wb_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  reg_num_t               push_num,
  input  data_t                  push_data,
  input  logic                   pop,
  input  logic                   squash,
  input  reg_num_t               squash_num,
  input  reg_num_t               rs,
  input  reg_num_t               rt,
  output logic [$clog2(DEPTH):0] count,
  output wb_entry_t              head,
  output logic [DEPTH-1:0]       rs_hit,
  output logic [DEPTH-1:0]       rt_hit
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  wb_entry_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  assign head = mem[rptr];
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rs_hit[i] = mem[i].valid && mem[i].num == rs;
      rt_hit[i] = mem[i].valid && mem[i].num == rt;
    end
  end
  // Popped slots drop their valid bit so only live entries answer pending lookups;
  // the push write comes last so a same-edge squash never hits the new (younger) entry.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (squash && mem[i].num == squash_num) mem[i].valid <= 1'b0;
      if (pop) begin
        mem[rptr].valid <= 1'b0;
        rptr <= rptr + AW'(1);
      end
      if (push) begin
        mem[wptr] <= '{valid: 1'b1, num: push_num, data: push_data};
        wptr <= wptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/wb_ctrl.sv
// wb_ctrl: register-file write port arbiter; ALU writes have priority over the queued mem writes
module wb_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   alu_valid,
  input  reg_num_t               alu_num,
  input  data_t                  alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  reg_num_t               mem_num,
  input  data_t                  mem_data,
  output logic                   reg_write,
  output reg_num_t               num_write,
  output data_t                  data_write,
  input  reg_num_t               rs,
  input  reg_num_t               rt,
  output logic                   rs_pending,
  output logic                   rt_pending,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  wb_entry_t head;
  logic [DEPTH-1:0] rs_hit, rt_hit;
  logic push, pop, squash, wr_en;
  reg_num_t wr_num;
  data_t wr_data;
  assign mem_ready = fifo_count < CW'(DEPTH);
  // Writes to r0 complete their handshake but are dropped here.
  always_comb begin
    push = mem_valid && mem_ready && mem_num != '0;
    pop = !alu_valid && fifo_count != '0;
    squash = alu_valid && alu_num != '0;
    wr_en = alu_valid ? squash : pop && head.valid;
    wr_num = alu_valid ? alu_num : head.num;
    wr_data = alu_valid ? alu_data : head.data;
  end
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push),
    .push_num   (mem_num),
    .push_data  (mem_data),
    .pop        (pop),
    .squash     (squash),
    .squash_num (alu_num),
    .rs         (rs),
    .rt         (rt),
    .count      (fifo_count),
    .head       (head),
    .rs_hit     (rs_hit),
    .rt_hit     (rt_hit)
  );
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      reg_write <= 1'b0;
      num_write <= '0;
      data_write <= '0;
    end else begin
      reg_write <= wr_en;
      if (wr_en) begin
        num_write <= wr_num;
        data_write <= wr_data;
      end
    end
  end
  assign rs_pending = rs != '0 && (|rs_hit || (reg_write && num_write == rs));
  assign rt_pending = rt != '0 && (|rt_hit || (reg_write && num_write == rt));
endmodule
